oam_dma_engine: RTL
===================

OAM_DMA_ENGINE -- requirements
Module: oam_dma_engine

Interface
REQ-001 SHALL have parameter P_DMA_REG_ADDR, 16'hFF46, IO register address that triggers a transfer.
REQ-002 SHALL have parameter P_OAM_BASE_ADDR, 16'hFE00, destination base address.
REQ-003 SHALL have parameter P_XFER_LEN, 8'd160, bytes per transfer.
REQ-004 SHALL have one clock and one reset: I_CLK  in  1  sole clock, rising edge.
REQ-005 SHALL have I_RESET_L  in  1  asynchronous reset, active-low.
REQ-006 SHALL have I_IOREG_ADDR  in  16  IO register bus address from the memory router.
REQ-007 SHALL have I_IOREG_DATA  in  8  IO register write data.
REQ-008 SHALL have I_IOREG_WE_L  in  1  IO register write strobe, active-low.
REQ-009 SHALL have I_IOREG_RE_L  in  1  IO register read strobe, active-low.
REQ-010 SHALL have O_IOREG_DATA  out  8  IO register read data.
REQ-011 SHALL have O_RDMA_ADDR  out  16  DMA read-port address to the router.
REQ-012 SHALL have I_RDMA_DATA  in  8  DMA read-port data from the router.
REQ-013 SHALL have O_RDMA_RE_L  out  1  DMA read strobe, active-low.
REQ-014 SHALL have O_WDMA_ADDR  out  16  DMA write-port address.
REQ-015 SHALL have O_WDMA_DATA  out  8  DMA write-port data.
REQ-016 SHALL have O_WDMA_WE_L  out  1  DMA write strobe, active-low.
REQ-017 SHALL have O_DMA_ACTIVE  out  1  high while a transfer is in progress (CPU bus lockout).
REQ-018 SHALL have O_DMA_DONE  out  1  one-cycle pulse on transfer completion.

Function
REQ-019 A trigger SHALL be a clock edge with I_IOREG_WE_L=0 and I_IOREG_ADDR==P_DMA_REG_ADDR; a simultaneous I_IOREG_RE_L=0 SHALL be ignored (write wins).
REQ-020 On trigger the block SHALL latch I_IOREG_DATA into the source-page register SRC, clear index IDX (8 bits) and enter state READ on the next cycle.
REQ-021 States SHALL be IDLE, READ, WAIT and WRITE; sequence per byte is READ->WAIT->WRITE, i.e. 3 cycles per byte and 480 cycles per transfer.
REQ-022 READ: O_RDMA_RE_L=0 and O_RDMA_ADDR={SRC,8'h00}+IDX.
REQ-023 WAIT: O_RDMA_RE_L=1; I_RDMA_DATA (valid the cycle after the READ cycle) SHALL be captured into the byte buffer at the end of WAIT.
REQ-024 WRITE: O_WDMA_WE_L=0, O_WDMA_ADDR=P_OAM_BASE_ADDR+IDX, O_WDMA_DATA=byte buffer.
REQ-025 After WRITE with IDX<P_XFER_LEN-1, IDX SHALL increment and the state SHALL return to READ.
REQ-026 After WRITE with IDX==P_XFER_LEN-1, the state SHALL go to IDLE and O_DMA_DONE SHALL be 1 for exactly that first IDLE cycle.
REQ-027 Strobes and addresses SHALL be decoded from registered state only; outside READ/WRITE both strobes SHALL be 1.
REQ-028 Outside READ, O_RDMA_ADDR SHALL hold its last value.
REQ-029 Outside WRITE, O_WDMA_ADDR and O_WDMA_DATA SHALL hold their last values.
REQ-030 O_DMA_ACTIVE SHALL be 1 in READ, WAIT and WRITE, and 0 in IDLE.
REQ-031 A trigger during an active transfer SHALL restart: new SRC, IDX=0, READ next cycle. The current-cycle strobe SHALL still be driven, and no O_DMA_DONE SHALL be issued for the aborted transfer.
REQ-032 A trigger coinciding with the final WRITE SHALL complete that write, suppress O_DMA_DONE and restart.
REQ-033 SRC SHALL be used as-is for all values 8'h00-8'hFF, with no clamping.
REQ-034 Address arithmetic SHALL be 16-bit modulo.
REQ-035 O_IOREG_DATA SHALL be SRC when I_IOREG_RE_L=0, I_IOREG_WE_L=1 and I_IOREG_ADDR==P_DMA_REG_ADDR; otherwise it SHALL be 8'h00.
REQ-036 IO register accesses to any other address SHALL have no effect.

Reset
REQ-037 I_RESET_L=0 SHALL asynchronously force state IDLE, SRC=8'h00, IDX=0 and buffer=8'h00.
REQ-038 During reset O_RDMA_RE_L=1, O_WDMA_WE_L=1, O_RDMA_ADDR=16'h0000, O_WDMA_ADDR=16'h0000, O_WDMA_DATA=8'h00, O_DMA_ACTIVE=0 and O_DMA_DONE=0.
REQ-039 Reset asserted mid-transfer SHALL abort without O_DMA_DONE; after release the block SHALL stay IDLE until a trigger.

Verification
REQ-040 Reset -> all outputs at the REQ-038 values, O_IOREG_DATA=8'h00.
REQ-041 Write 8'hC1 to FF46, model memory byte[a]=a[7:0]^8'h5A -> first read C100, then write FE00=8'h5A, last write FE9F=8'hC5, 480 active cycles, one O_DMA_DONE pulse.
REQ-042 After REQ-041, read FF46 -> O_IOREG_DATA=8'hC1; reading FF45 -> 8'h00.
REQ-043 Write 8'hD0 to FF46 at IDX=50 -> next cycle READ D000, next write FE00, no DONE for the aborted transfer, 480 cycles to DONE.
REQ-044 Assert I_RESET_L=0 mid-WRITE, between clock edges -> O_WDMA_WE_L=1 immediately; after release the block stays IDLE, with no strobes.
REQ-045 Write 8'hC1 to FF47 and FF45 -> no strobes, O_DMA_ACTIVE stays 0.

Source files
------------

// File: rtl/oam_dma_engine.sv
// oam_dma_engine
//   Copies P_XFER_LEN bytes from page {SRC,8'h00} to the OAM window at
//   P_OAM_BASE_ADDR. A transfer starts when the CPU writes the source page
//   to the IO register at P_DMA_REG_ADDR. Each byte takes three cycles:
//   READ (read strobe), WAIT (read data captured at end of cycle), and
//   WRITE (write strobe).
//
// Ports
//   I_CLK, I_RESET_L        clock (rising edge), async active-low reset
//   I_IOREG_ADDR/DATA       IO register bus address / write data
//   I_IOREG_WE_L/RE_L       IO register write / read strobes (active-low)
//   O_IOREG_DATA            IO register read data (SRC when FF46 is read)
//   O_RDMA_ADDR/RE_L        DMA read port address / strobe (active-low)
//   I_RDMA_DATA             DMA read data, valid the cycle after READ
//   O_WDMA_ADDR/DATA/WE_L   DMA write port address / data / strobe
//   O_DMA_ACTIVE            high while a transfer runs (CPU bus lockout)
//   O_DMA_DONE              one-cycle pulse in the first IDLE cycle after
//                           the last byte is written
//   O_DBG_STATE             current FSM state, for observation only
//
// Handshake: there is no back-pressure. A strobe is asserted for exactly the
// one cycle the FSM sits in READ or WRITE; the read port must return data in
// the following cycle.
module oam_dma_engine #(
  parameter logic [15:0] P_DMA_REG_ADDR  = 16'hFF46,
  parameter logic [15:0] P_OAM_BASE_ADDR = 16'hFE00,
  parameter logic [7:0]  P_XFER_LEN      = 8'd160
) (
  input  logic        I_CLK,
  input  logic        I_RESET_L,
  input  logic [15:0] I_IOREG_ADDR,
  input  logic [7:0]  I_IOREG_DATA,
  input  logic        I_IOREG_WE_L,
  input  logic        I_IOREG_RE_L,
  output logic [7:0]  O_IOREG_DATA,
  output logic [15:0] O_RDMA_ADDR,
  input  logic [7:0]  I_RDMA_DATA,
  output logic        O_RDMA_RE_L,
  output logic [15:0] O_WDMA_ADDR,
  output logic [7:0]  O_WDMA_DATA,
  output logic        O_WDMA_WE_L,
  output logic        O_DMA_ACTIVE,
  output logic        O_DMA_DONE,
  output logic [1:0]  O_DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [7:0]  src, src_next;
  logic [7:0]  idx, idx_next;
  logic [7:0]  byte_buf, buf_next;
  logic [15:0] rd_addr, rd_addr_next;
  logic [15:0] wr_addr, wr_addr_next;
  logic [7:0]  wr_data, wr_data_next;
  logic        done, done_next;
  logic        trigger;
  logic        last_byte;

  // A write to the DMA register starts (or restarts) a transfer; a
  // simultaneous read strobe is irrelevant here.
  assign trigger   = !I_IOREG_WE_L && (I_IOREG_ADDR == P_DMA_REG_ADDR);
  assign last_byte = (idx == P_XFER_LEN - 8'd1);

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state    <= S_IDLE;
      src      <= 8'h00;
      idx      <= 8'h00;
      byte_buf <= 8'h00;
      rd_addr  <= 16'h0000;
      wr_addr  <= 16'h0000;
      wr_data  <= 8'h00;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      src      <= src_next;
      idx      <= idx_next;
      byte_buf <= buf_next;
      rd_addr  <= rd_addr_next;
      wr_addr  <= wr_addr_next;
      wr_data  <= wr_data_next;
      done     <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    src_next     = src;
    idx_next     = idx;
    buf_next     = byte_buf;
    rd_addr_next = rd_addr;
    wr_addr_next = wr_addr;
    wr_data_next = wr_data;
    done_next    = 1'b0;

    case (state)
      S_IDLE:  state_next = S_IDLE;
      S_READ:  state_next = S_WAIT;
      S_WAIT: begin
        state_next = S_WRITE;
        buf_next   = I_RDMA_DATA;
      end
      S_WRITE: begin
        if (last_byte) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = S_READ;
          idx_next   = idx + 8'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Restart overrides everything, including the completion pulse of a
    // transfer whose final write is happening this cycle.
    if (trigger) begin
      src_next   = I_IOREG_DATA;
      idx_next   = 8'h00;
      state_next = S_READ;
      done_next  = 1'b0;
    end

    // Port addresses/data are loaded on entry to READ/WRITE so the outputs
    // come straight from registers and hold their value in other states.
    if (state_next == S_READ) begin
      rd_addr_next = {src_next, 8'h00} + {8'h00, idx_next};
    end
    if (state_next == S_WRITE) begin
      wr_addr_next = P_OAM_BASE_ADDR + {8'h00, idx_next};
      wr_data_next = buf_next;
    end
  end

  assign O_RDMA_RE_L  = (state != S_READ);
  assign O_WDMA_WE_L  = (state != S_WRITE);
  assign O_RDMA_ADDR  = rd_addr;
  assign O_WDMA_ADDR  = wr_addr;
  assign O_WDMA_DATA  = wr_data;
  assign O_DMA_ACTIVE = (state != S_IDLE);
  assign O_DMA_DONE   = done;
  assign O_DBG_STATE  = state;

  assign O_IOREG_DATA = (!I_IOREG_RE_L && I_IOREG_WE_L &&
                         (I_IOREG_ADDR == P_DMA_REG_ADDR)) ? src : 8'h00;

endmodule
